// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-port data-memory responder with a programmable number
//                of wait states. Accepts one load/store request at a time,
//                returns a one-cycle response pulse WAIT_CYCLES+1 cycles after
//                the request cycle, and allows a new request in the response
//                cycle for back-to-back operation.
//
//  Parameters  : ADDR_W      - word-index width (depth = 2**ADDR_W words)
//                WAIT_CYCLES - extra wait states per access (0..15)
//
//  Ports       : clk, rst                 - clock, async active-high reset
//                req_valid/req_write      - request strobe, 1 = store
//                req_addr/req_wdata/req_be- byte address, store data, lanes
//                req_ready                - request can be accepted
//                resp_valid/resp_rdata/
//                resp_err                 - response pulse, load data, fault
//                busy                     - access in flight (WAIT or RESP)
//
//  Options     : `define DMEM_MISALIGN_TRAP_EN to fault non-word-aligned
//                accesses (resp_err=1, no write, rdata=0).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 13,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         c_DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               w_enter_resp;

    // Captured request, used while the access sits in WAIT
    logic               r_write;
    logic [ADDR_W-1:0]  r_idx;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_mis;

    logic [31:0]        r_mem [c_DEPTH];

    logic               w_accept;
    logic [ADDR_W-1:0]  w_idx_in;
    logic               w_mis_in;

    logic               w_acc_write;
    logic [ADDR_W-1:0]  w_acc_idx;
    logic [31:0]        w_acc_wdata;
    logic [3:0]         w_acc_be;
    logic               w_acc_mis;
    logic               w_mem_we;

    // Upper address bits wrap modulo depth; low bits matter only for the trap
    logic               w_unused_addr_bits;
    assign w_unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    assign w_accept = req_valid & req_ready;
    assign w_idx_in = req_addr[ADDR_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis_in = |req_addr[1:0];
`else
    assign w_mis_in = 1'b0;
`endif

    // When RESP is entered straight from an accept (WAIT_CYCLES == 0) the
    // request fields are still on the inputs; from WAIT they come from the
    // captured copy. Accept cannot happen in WAIT because req_ready is low.
    assign w_acc_write = w_accept ? req_write : r_write;
    assign w_acc_idx   = w_accept ? w_idx_in  : r_idx;
    assign w_acc_wdata = w_accept ? req_wdata : r_wdata;
    assign w_acc_be    = w_accept ? req_be    : r_be;
    assign w_acc_mis   = w_accept ? w_mis_in  : r_mis;

    assign w_mem_we = w_enter_resp & w_acc_write & ~w_acc_mis & ~rst;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_mis      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_idx   <= w_idx_in;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_mis   <= w_mis_in;
            end
            req_ready  <= (w_state_nxt != S_WAIT);
            busy       <= (w_state_nxt != S_IDLE);
            resp_valid <= w_enter_resp;
            resp_err   <= w_enter_resp & w_acc_mis;
            // Read happens on the same edge as a store would write, so a load
            // sees the word as it stands on entry to RESP.
            if (w_enter_resp && !w_acc_write && !w_acc_mis) begin
                resp_rdata <= r_mem[w_acc_idx];
            end else begin
                resp_rdata <= 32'd0;
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) begin
                    r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Requests are driven
//                on the falling edge; expected responses are pushed into a
//                scoreboard queue at acceptance and popped when resp_valid
//                is seen. A word-level reference memory produces load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W      = 13;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 1 << ADDR_W;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] model [int];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every response must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: resp_valid=1 with no outstanding request, cycle %0d", cyc);
            end else begin
                mon_e = q.pop_front();
                n_tests++;
                if (resp_rdata !== mon_e.rdata) begin
                    n_fail++;
                    $display("FAIL resp_rdata: got %h expected %h", resp_rdata, mon_e.rdata);
                end
                n_tests++;
                if (resp_err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL resp_err: got %b expected %b", resp_err, mon_e.err);
                end
                n_tests++;
                if (cyc - mon_e.acc !== WAIT_CYCLES + 1) begin
                    n_fail++;
                    $display("FAIL latency: got %0d expected %0d", cyc - mon_e.acc, WAIT_CYCLES + 1);
                end
            end
        end
    end

    // Present a request (called on a falling edge) and hold it until accepted.
    // Returns on the falling edge after the accept edge with req_valid still 1.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output int acc);
        exp_t        e;
        int          idx;
        int          guard;
        logic        mis;
        logic [31:0] w;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        guard     = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b expected 1", req_ready);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        idx = int'((addr >> 2) & 32'(DEPTH - 1));
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        w = model.exists(idx) ? model[idx] : 32'h0;
        e.err = mis;
        e.acc = acc;
        if (mis) begin
            e.rdata = 32'h0;
        end else if (wr) begin
            e.rdata = 32'h0;
            for (int i = 0; i < 4; i++)
                if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            model[idx] = w;
        end else begin
            e.rdata = w;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drop();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((q.size() != 0 || busy) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (q.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d busy=%b expected 0/0", q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        n_tests++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", resp_valid); end
        n_tests++;
        if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", resp_rdata); end
        n_tests++;
        if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", resp_err); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int a;
        send(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, a);
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready: got %b expected 0", req_ready); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b expected 1", busy); end
        drop();
        wait_done();
        send(1'b0, 32'h40, 32'h0, 4'hF, a);
        drop();
        wait_done();
    endtask

    task automatic test_byte_lanes();
        int a;
        send(1'b1, 32'h40, 32'h00000011, 4'b0001, a); drop(); wait_done();
        send(1'b0, 32'h40, 32'h0, 4'hF, a);           drop(); wait_done();
        send(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, a); drop(); wait_done();
        send(1'b0, 32'h40, 32'h0, 4'hF, a);           drop(); wait_done();
        send(1'b1, 32'h44, 32'hAABBCCDD, 4'hF, a);    drop(); wait_done();
        send(1'b1, 32'h44, 32'h11223344, 4'b1010, a); drop(); wait_done();
        send(1'b0, 32'h44, 32'h0, 4'hF, a);           drop(); wait_done();
    endtask

    task automatic test_wrap();
        int a;
        send(1'b0, 32'h8040, 32'h0, 4'hF, a);         drop(); wait_done();
        send(1'b1, 32'h80000048, 32'h5A5A0F0F, 4'hF, a); drop(); wait_done();
        send(1'b0, 32'h48, 32'h0, 4'hF, a);           drop(); wait_done();
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        send(1'b1, 32'h100, 32'h01010101, 4'hF, a1);
        send(1'b1, 32'h104, 32'h02020202, 4'hF, a2);
        drop();
        wait_done();
        send(1'b0, 32'h100, 32'h0, 4'hF, a1);
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_wait_ready: got %b expected 0", req_ready); end
        send(1'b0, 32'h104, 32'h0, 4'hF, a2);
        drop();
        n_tests++;
        if (a2 - a1 !== WAIT_CYCLES + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected %0d", a2 - a1, WAIT_CYCLES + 1);
        end
        wait_done();
    endtask

    task automatic test_reset_in_wait();
        int          a;
        exp_t        e;
        logic [31:0] old;
        send(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, a); drop(); wait_done();
        old = model[32];
        send(1'b1, 32'h80, 32'h12345678, 4'hF, a);
        drop();
        // The pending store is discarded by reset: undo its model effect
        model[32] = old;
        e = q.pop_back();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready: got %b expected 1", req_ready); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
        n_tests++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", resp_valid); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(1'b0, 32'h80, 32'h0, 4'hF, a); drop(); wait_done();
    endtask

    task automatic test_misalign();
        int a;
        send(1'b1, 32'h42, 32'hA5A5A5A5, 4'hF, a); drop(); wait_done();
        send(1'b0, 32'h40, 32'h0, 4'hF, a);        drop(); wait_done();
        send(1'b0, 32'h41, 32'h0, 4'hF, a);        drop(); wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_wrap();
        test_back_to_back();
        test_reset_in_wait();
        test_misalign();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 13; word-index width, memory depth 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 0..15; extra wait states per access.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
REQ-008 req_wdata  input  32  store data.
REQ-009 req_be  input  4  byte enables; bit n enables byte lane n (bits 8n+7:8n).
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  32  load data; valid only with resp_valid.
REQ-013 resp_err  output  1  access fault; valid only with resp_valid.
REQ-014 busy  output  1  request in flight (state WAIT or RESP).

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; write, word index, wdata, be and the misalignment flag are captured.
REQ-017 req_ready SHALL be 1 in IDLE and RESP and 0 in WAIT.
REQ-018 On accept: WAIT_CYCLES=0 -> RESP next cycle; otherwise -> WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-019 In WAIT the counter SHALL decrement each cycle; at 0 -> RESP next cycle.
REQ-020 Latency from accept edge to resp_valid high SHALL be WAIT_CYCLES+1 cycles.
REQ-021 resp_valid SHALL be 1 only in RESP, exactly one cycle per accepted request.
REQ-022 Stores SHALL update memory on the edge entering RESP, only in lanes with be=1; be=0000 leaves memory unchanged and is still acknowledged.
REQ-023 Loads SHALL return the full word as it stands at entry to RESP; resp_rdata SHALL be 0 for stores.
REQ-024 In RESP, a new accept SHALL start the next access (back-to-back); otherwise -> IDLE.
REQ-025 Address bits above ADDR_W+1 SHALL be ignored (wrap-around modulo depth).
REQ-026 req_valid while req_ready=0 SHALL be ignored; the requester holds it.

Reset
REQ-027 rst high SHALL immediately force IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, req_ready 1.
REQ-028 Reset during WAIT SHALL discard the pending access; memory SHALL not be written.
REQ-029 Memory contents SHALL not be initialised by reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN controls alignment checking.
REQ-031 Defined: req_addr[1:0]!=0 flags the access; a flagged access completes with normal latency, resp_err=1, resp_rdata=0, no memory write.
REQ-032 Not defined: req_addr[1:0] ignored; resp_err tied to 0.

Verification
REQ-033 WAIT_CYCLES=2: store 0xDEADBEEF, be=1111 to 0x40, then load 0x40 -> each resp_valid 3 cycles after accept; load rdata=0xDEADBEEF.
REQ-034 Word 0x40=0xDEADBEEF; store 0x00000011, be=0001, then load -> rdata=0xDEADBE11.
REQ-035 Load 0x8040 with ADDR_W=13 -> returns word at 0x0040 (wrap).
REQ-036 req_valid held high across two loads -> second accepted in the RESP cycle of the first; two resp_valid pulses 3 cycles apart; req_ready=0 in WAIT.
REQ-037 rst asserted mid-WAIT of store 0x12345678 to 0x80 -> outputs reset asynchronously; later load 0x80 returns the old value.
REQ-038 With DMEM_MISALIGN_TRAP_EN: store to 0x42 -> resp_err=1, memory unchanged; without macro -> resp_err=0, word 0x40 written.
